note_glyph_loader: RTL
======================

Name: note_glyph_loader

Overview:
- Controller that sequences updates of the note-name character display.
- Watches the 14-bit tone divider `origin` and maps it to one of 22 glyphs: 21 notes plus an idle pattern.
- On a stable change, streams the glyph's 16 × 24-bit bitmap rows from a glyph ROM into the display's row registers.
- Writes occur only during vertical blank, so a frame never shows a mixed glyph.
- Sits between the key/tone logic and vga_char; replaces per-edge combinational bitmap muxing.

Parameters:
- STABLE_CYCLES, 1024: cycles `origin` must hold unchanged before a new glyph is requested.
- SYNC_TO_FRAME, 1: 1 = a load starts only on frame_start; 0 = a load starts immediately.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- origin  in  14  tone divider value from the key decoder
- frame_start  in  1  one-cycle pulse at start of vertical blank
- rom_en  out  1  glyph ROM read strobe
- rom_addr  out  9  {glyph_idx[4:0], row[3:0]}
- rom_data  in  24  ROM row data, valid exactly 1 cycle after rom_en
- line_we  out  1  display row write strobe
- line_idx  out  4  display row 0..15
- line_data  out  24  row bitmap
- busy  out  1  load sequence in progress
- cur_glyph  out  5  glyph currently fully shown on the display

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Decode (combinational) from `origin` to glyph index:
  - 6826, 7871, 8798, 9224, 10005, 10701, 11321 → 0..6 (high do..si)
  - 11606, 12126, 12591, 12804, 13194, 13524, 13852 → 7..13 (mid)
  - 13994, 14255, 14487, 14593, 14789, 14963, 15117 → 14..20 (low)
  - any other value → 21 (IDLE glyph)
- Stability filter:
  - origin_q registers `origin`.
  - stab_cnt clears to 0 when origin != origin_q; otherwise increments, saturating at STABLE_CYCLES.
  - When stab_cnt == STABLE_CYCLES and decode(origin_q) != tgt_idx: tgt_idx <= decode(origin_q) and pending <= 1.
- Reset values:
  - FSM = IDLE; tgt_idx = 21; pending = 1, which forces an IDLE-glyph load on the first frame.
  - cur_glyph = 21; stab_cnt = 0.
  - All strobes 0; rom_addr, line_idx, line_data = 0; busy = 0.
- FSM states: IDLE, WAIT_VB, FETCH, DRAIN.
- IDLE:
  - If pending: go to WAIT_VB, or go to FETCH directly when SYNC_TO_FRAME = 0.
  - Entering FETCH latches load_idx = tgt_idx and clears pending.
- WAIT_VB:
  - On frame_start: go to FETCH; latch load_idx = tgt_idx; clear pending.
  - A frame_start in the same cycle IDLE decides to leave is not seen; the load waits for the next frame.
- FETCH:
  - Row counter n runs 0..15, one per cycle.
  - rom_en = 1 and rom_addr = {load_idx, n}.
  - From the second FETCH cycle on: line_we = 1, line_idx = n-1, line_data = rom_data.
  - After n = 15, go to DRAIN.
- DRAIN:
  - line_we = 1, line_idx = 15, line_data = rom_data.
  - cur_glyph <= load_idx; next state IDLE.
- Timing:
  - Load length is 17 cycles from FETCH entry to the last write.
  - busy = (state != IDLE) and is combinational from state.
- Change during a load:
  - The load is never aborted. The filter keeps running and may set pending and a new tgt_idx.
  - After DRAIN, IDLE re-issues the load on the next frame.
  - Intermediate targets are collapsed; only the latest tgt_idx is loaded.
- Same-glyph flicker: if origin goes A→B→A within STABLE_CYCLES, no request is made.
- frame_start while in FETCH or DRAIN is ignored.
- Reset mid-load: async clear to reset values; the display reloads the IDLE glyph on the next frame.

Decomposition:
- Shared package holds:
  - NOTE_DIV table (21 divider constants)
  - GLYPH_IDLE = 21, GLYPH_W = 24, GLYPH_ROWS = 16
  - FSM state enum
- Sub-module note_glyph_decode: pure combinational origin → glyph index. Shared with the tone generator for note indexing.
- Glyph ROM (22 × 16 × 24) is external, so the loader stays a pure controller.

Test Plan:
- Release reset, pulse frame_start at cycle 20 → one 17-cycle load:
  - rom_addr 21*16+0..15
  - 16 line_we pulses with line_idx 0..15
  - cur_glyph = 21; busy low afterwards.
- Hold origin = 12126 for STABLE_CYCLES, then frame_start → rom_addr base 8*16 = 128; line_data equals the ROM rows for glyph 8; cur_glyph = 8.
- Toggle origin 6826 ↔ 7871 every 100 cycles (STABLE_CYCLES = 1024) → no rom_en, no line_we; cur_glyph unchanged.
- Change origin 13994 → 15117 during a glyph-14 FETCH → glyph-14 load completes all 16 rows; the next frame loads glyph 20; no missing rows.
- With SYNC_TO_FRAME = 0, origin = 9224 → FETCH starts one cycle after pending is set, with no frame_start needed; cur_glyph = 3.
- Assert rst_n low at FETCH row 7 → outputs clear asynchronously; after release, the first frame loads glyph 21.

Source files
------------

// File: rtl/note_glyph_loader_pkg.sv
// Shared constants for the note-name glyph loader: tone-divider table,
// glyph geometry and the loader FSM state encoding.
package note_glyph_loader_pkg;

  localparam int GLYPH_IDLE = 21;
  localparam int GLYPH_W    = 24;
  localparam int GLYPH_ROWS = 16;
  localparam int NOTE_CNT   = 21;

  // Index in this table is the glyph index: high do..si, mid do..si, low do..si.
  localparam logic [13:0] NOTE_DIV [NOTE_CNT] = '{
    14'd6826,  14'd7871,  14'd8798,  14'd9224,  14'd10005, 14'd10701, 14'd11321,
    14'd11606, 14'd12126, 14'd12591, 14'd12804, 14'd13194, 14'd13524, 14'd13852,
    14'd13994, 14'd14255, 14'd14487, 14'd14593, 14'd14789, 14'd14963, 14'd15117
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_VB,
    ST_FETCH,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/note_glyph_loader_if.sv
// Glyph ROM read port and display row-write port of the loader.
interface note_glyph_loader_if;
  import note_glyph_loader_pkg::*;

  // Handshake: rom_en is a read strobe with no backpressure and rom_data is
  // valid exactly one cycle after it; line_we is a write strobe that the
  // display always accepts in the cycle it is high, with line_idx/line_data.
  logic                 rom_en;
  logic [8:0]           rom_addr;
  logic [GLYPH_W-1:0]   rom_data;
  logic                 line_we;
  logic [3:0]           line_idx;
  logic [GLYPH_W-1:0]   line_data;

  modport master (
    output rom_en, rom_addr, line_we, line_idx, line_data,
    input  rom_data
  );

  modport slave (
    input  rom_en, rom_addr, line_we, line_idx, line_data,
    output rom_data
  );

endinterface

// File: rtl/note_glyph_decode.sv
// Maps a tone divider value to its note glyph index; unknown values select
// the idle glyph.
module note_glyph_decode
  import note_glyph_loader_pkg::*;
(
  input  logic [13:0] origin,
  output logic [4:0]  glyph_idx
);

  always_comb begin
    glyph_idx = 5'(GLYPH_IDLE);
    for (int i = 0; i < NOTE_CNT; i++) begin
      if (origin == NOTE_DIV[i]) glyph_idx = 5'(i);
    end
  end

endmodule

// File: rtl/note_glyph_loader.sv
// Streams the glyph selected by a stable tone divider from the glyph ROM into
// the display row registers, optionally only during vertical blank.
module note_glyph_loader
  import note_glyph_loader_pkg::*;
#(
  parameter int STABLE_CYCLES = 1024,
  parameter bit SYNC_TO_FRAME = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [13:0]           origin,
  input  logic                  frame_start,
  note_glyph_loader_if.master   bus,
  output logic                  busy,
  output logic [4:0]            cur_glyph,
  output state_t                fsm_state
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] STAB_MAX = CNT_W'(STABLE_CYCLES);

  state_t           state;
  logic [13:0]      origin_q;
  logic [CNT_W-1:0] stab_cnt;
  logic [4:0]       dec_q;
  logic [4:0]       tgt_idx;
  logic [4:0]       load_idx;
  logic             pending;
  logic [3:0]       row;
  logic             rom_en_q;
  logic [8:0]       rom_addr_q;
  logic             line_we_q;
  logic [3:0]       line_idx_q;
  logic             req;
  logic             start_load;

  note_glyph_decode u_decode (
    .origin    (origin_q),
    .glyph_idx (dec_q)
  );

  assign req = (stab_cnt == STAB_MAX) && (dec_q != tgt_idx);
  assign start_load = (state == ST_IDLE && pending && !SYNC_TO_FRAME) ||
                      (state == ST_WAIT_VB && frame_start);

  // Stability filter: a target only moves after origin has held still.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      origin_q <= '0;
      stab_cnt <= '0;
      tgt_idx  <= 5'(GLYPH_IDLE);
    end else begin
      origin_q <= origin;
      if (origin != origin_q) stab_cnt <= '0;
      else if (stab_cnt != STAB_MAX) stab_cnt <= stab_cnt + CNT_W'(1);
      if (req) tgt_idx <= dec_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pending    <= 1'b1;
      load_idx   <= 5'(GLYPH_IDLE);
      cur_glyph  <= 5'(GLYPH_IDLE);
      row        <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      line_we_q  <= 1'b0;
      line_idx_q <= '0;
    end else begin
      // A request raised in the same cycle a load starts must survive.
      if (start_load) pending <= 1'b0;
      if (req) pending <= 1'b1;
      case (state)
        ST_IDLE: if (pending && SYNC_TO_FRAME) state <= ST_WAIT_VB;
        ST_FETCH: begin
          line_we_q  <= 1'b1;
          line_idx_q <= row;
          if (row == 4'd15) begin
            state      <= ST_DRAIN;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
          end else begin
            row        <= row + 4'd1;
            rom_addr_q <= {load_idx, row + 4'd1};
          end
        end
        ST_DRAIN: begin
          state      <= ST_IDLE;
          line_we_q  <= 1'b0;
          line_idx_q <= '0;
          cur_glyph  <= load_idx;
        end
        default: ;
      endcase
      if (start_load) begin
        state      <= ST_FETCH;
        load_idx   <= tgt_idx;
        row        <= '0;
        rom_en_q   <= 1'b1;
        rom_addr_q <= {tgt_idx, 4'd0};
      end
    end
  end

  assign bus.rom_en    = rom_en_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.line_we   = line_we_q;
  assign bus.line_idx  = line_idx_q;
  assign bus.line_data = line_we_q ? bus.rom_data : '0;
  assign busy          = (state != ST_IDLE);
  assign fsm_state     = state;

endmodule
